// File: rtl/ctr_digits_pkg.sv
// ctr_digits_pkg: shared digit width, per-mode digit maxima and direction encodings
// for the cascaded digit counter.
package ctr_digits_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BIN_MAX = 4'd15;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [DIGIT_W-1:0] digit_max(input bit bcd);
        return bcd ? BCD_MAX : BIN_MAX;
    endfunction

endpackage

// File: rtl/ctr_digit_cell.sv
// ctr_digit_cell: one 4-bit counter digit with a combinational carry/borrow output
// and a load path that clamps out-of-range BCD digits to the digit maximum.
module ctr_digit_cell
    import ctr_digits_pkg::*;
#(
    parameter int MODE_BCD = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cin,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               cout
);

    localparam logic [DIGIT_W-1:0] MAX = digit_max(MODE_BCD != 0);

    logic               at_end;
    logic [DIGIT_W-1:0] d_clamp;
    logic [DIGIT_W-1:0] nxt;

    always_comb begin
        at_end  = (up == DIR_UP) ? (q == MAX) : (q == '0);
        d_clamp = (d > MAX) ? MAX : d;
        nxt     = at_end ? ((up == DIR_UP) ? '0 : MAX)
                         : ((up == DIR_UP) ? q + 4'd1 : q - 4'd1);
    end

    assign cout = cin & at_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (load)
            q <= d_clamp;
        else if (cin)
            q <= nxt;
    end

endmodule

// File: rtl/ctr_digits.sv
// ctr_digits: DIGITS cascaded BCD/binary digits, up/down with load, terminal count and
// sticky overflow. Define CTR_DIGITS_SAT_EN to saturate at the ends instead of wrapping.
module ctr_digits
    import ctr_digits_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int MODE_BCD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     up,
    input  logic                     load,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    output logic [DIGIT_W*DIGITS-1:0] q,
    output logic                     tc,
    output logic                     ovf
);

    localparam logic [DIGIT_W-1:0] MAX = digit_max(MODE_BCD != 0);

    logic [DIGITS:0] carry;
    logic            all_end;
    logic            unused_carry;

    assign all_end = (up == DIR_UP) ? (q == {DIGITS{MAX}}) : (q == '0);
    assign tc      = en & all_end;

`ifdef CTR_DIGITS_SAT_EN
    // Starving the chain at the end points freezes every digit in place.
    assign carry[0] = en & ~all_end;
`else
    assign carry[0] = en;
`endif

    // The wrap event is taken from tc, so the final carry is not needed.
    assign unused_carry = carry[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        ctr_digit_cell #(
            .MODE_BCD(MODE_BCD)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .cin  (carry[i]),
            .up   (up),
            .load (load),
            .d    (din[i*DIGIT_W +: DIGIT_W]),
            .q    (q[i*DIGIT_W +: DIGIT_W]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf <= 1'b0;
        else if (load)
            ovf <= 1'b0;
        else if (tc)
            ovf <= 1'b1;
    end

endmodule

// File: tb/tb_ctr_digits.sv
// tb_ctr_digits: randomized and directed checks of a BCD and a binary two-digit counter
// against an integer-valued reference model.
module tb_ctr_digits;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] q0, q1;
    logic       tc0, tc1, ovf0, ovf1;

    int passed = 0;
    int total  = 0;

    int   mv[2];
    bit   mo[2];
    int   mb[2] = '{10, 16};
    bit   exp_tc[2];
    logic obs_tc[2];

    always #5 clk = ~clk;

    ctr_digits #(.DIGITS(2), .MODE_BCD(1)) dut_bcd (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .q(q0), .tc(tc0), .ovf(ovf0)
    );

    ctr_digits #(.DIGITS(2), .MODE_BCD(0)) dut_bin (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .q(q1), .tc(tc1), .ovf(ovf1)
    );

    function automatic logic [7:0] enc(input int v, input int b);
        logic [7:0] r;
        r[3:0] = 4'(v % b);
        r[7:4] = 4'((v / b) % b);
        return r;
    endfunction

    function automatic int dec(input logic [7:0] d, input int b);
        int lo = int'(d[3:0]);
        int hi = int'(d[7:4]);
        if (b == 10 && lo > 9) lo = 9;
        if (b == 10 && hi > 9) hi = 9;
        return hi * b + lo;
    endfunction

    function automatic logic [7:0] obs_q(input int k);
        return (k == 0) ? q0 : q1;
    endfunction

    function automatic logic obs_ovf(input int k);
        return (k == 0) ? ovf0 : ovf1;
    endfunction

    function automatic bit model_tc(input int k, input bit e, input bit u);
        return e && (u ? (mv[k] == mb[k] * mb[k] - 1) : (mv[k] == 0));
    endfunction

    task automatic model_step(input int k, input bit l, input bit e, input bit u, input logic [7:0] d);
        int top = mb[k] * mb[k] - 1;
        bit sat = 1'b0;
`ifdef CTR_DIGITS_SAT_EN
        sat = 1'b1;
`endif
        if (l) begin
            mv[k] = dec(d, mb[k]);
            mo[k] = 1'b0;
        end else if (e && u) begin
            if (mv[k] == top) begin
                mo[k] = 1'b1;
                mv[k] = sat ? top : 0;
            end else mv[k]++;
        end else if (e) begin
            if (mv[k] == 0) begin
                mo[k] = 1'b1;
                mv[k] = sat ? 0 : top;
            end else mv[k]--;
        end
    endtask

    // Called at a falling edge; returns #1 after the next rising edge.
    task automatic tick(input bit l, input bit e, input bit u, input logic [7:0] d);
        load = l; en = e; up = u; din = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_tc[k] = model_tc(k, e, u);
            obs_tc[k] = (k == 0) ? tc0 : tc1;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, l, e, u, d);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin mv[k] = 0; mo[k] = 1'b0; end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q(k) !== 8'h00 || obs_ovf(k) !== 1'b0)
                $display("FAIL reset_state dut%0d q=%h ovf=%b expected q=00 ovf=0", k, obs_q(k), obs_ovf(k));
            else passed++;
        end
        en = 1'b1; up = 1'b0;
        #1;
        total++;
        if (tc0 !== 1'b1 || tc1 !== 1'b1)
            $display("FAIL reset_tc_down tc=%b%b expected 11", tc0, tc1);
        else passed++;
        en = 1'b0; up = 1'b1;
        #1;
        total++;
        if (tc0 !== 1'b0 || tc1 !== 1'b0)
            $display("FAIL reset_tc_idle tc=%b%b expected 00", tc0, tc1);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_up;
        for (int n = 0; n < 100; n++) begin
            tick(1'b0, 1'b1, 1'b1, 8'h00);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_tc[k] !== exp_tc[k] || obs_q(k) !== enc(mv[k], mb[k]) || obs_ovf(k) !== mo[k])
                    $display("FAIL count_up dut%0d edge %0d tc/q/ovf=%b/%h/%b expected %b/%h/%b",
                             k, n, obs_tc[k], obs_q(k), obs_ovf(k), exp_tc[k], enc(mv[k], mb[k]), mo[k]);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (q0 !== 8'h00 || ovf0 !== 1'b1)
            $display("FAIL bcd_wrap_up q=%h ovf=%b expected q=00 ovf=1", q0, ovf0);
        else passed++;
    endtask

    task automatic test_count_down;
        tick(1'b1, 1'b0, 1'b1, 8'h47);
        @(negedge clk);
        for (int n = 0; n < 48; n++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_tc[k] !== exp_tc[k] || obs_q(k) !== enc(mv[k], mb[k]) || obs_ovf(k) !== mo[k])
                    $display("FAIL count_down dut%0d edge %0d tc/q/ovf=%b/%h/%b expected %b/%h/%b",
                             k, n, obs_tc[k], obs_q(k), obs_ovf(k), exp_tc[k], enc(mv[k], mb[k]), mo[k]);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (q0 !== 8'h99 || ovf0 !== 1'b1)
            $display("FAIL bcd_wrap_down q=%h ovf=%b expected q=99 ovf=1", q0, ovf0);
        else passed++;
        tick(1'b1, 1'b0, 1'b0, 8'h12);
        total++;
        if (ovf0 !== 1'b0 || q0 !== 8'h12)
            $display("FAIL load_clears_ovf q=%h ovf=%b expected q=12 ovf=0", q0, ovf0);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_binary_and_clamp;
        logic [7:0] loads[3] = '{8'h0F, 8'hFF, 8'hA3};
        for (int j = 0; j < 3; j++) begin
            tick(1'b1, 1'b0, 1'b1, loads[j]);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_q(k) !== enc(mv[k], mb[k]))
                    $display("FAIL load dut%0d din=%h q=%h expected %h", k, loads[j], obs_q(k), enc(mv[k], mb[k]));
                else passed++;
            end
            @(negedge clk);
            tick(1'b0, 1'b1, 1'b1, 8'h00);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_tc[k] !== exp_tc[k] || obs_q(k) !== enc(mv[k], mb[k]) || obs_ovf(k) !== mo[k])
                    $display("FAIL up_after_load dut%0d din=%h tc/q/ovf=%b/%h/%b expected %b/%h/%b",
                             k, loads[j], obs_tc[k], obs_q(k), obs_ovf(k), exp_tc[k], enc(mv[k], mb[k]), mo[k]);
                else passed++;
            end
            @(negedge clk);
        end
        tick(1'b1, 1'b0, 1'b1, 8'h99);
        @(negedge clk);
        tick(1'b1, 1'b1, 1'b1, 8'h34);
        total++;
        if (obs_tc[0] !== 1'b1 || q0 !== 8'h34 || ovf0 !== 1'b0)
            $display("FAIL load_beats_tc tc=%b q=%h ovf=%b expected tc=1 q=34 ovf=0", obs_tc[0], q0, ovf0);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        tick(1'b1, 1'b0, 1'b1, 8'h55);
        @(negedge clk);
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        total++;
        if (q0 !== 8'h56)
            $display("FAIL pre_reset q=%h expected 56", q0);
        else passed++;
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mo[k] = 1'b0;
            total++;
            if (obs_q(k) !== 8'h00 || obs_ovf(k) !== 1'b0)
                $display("FAIL async_reset dut%0d q=%h ovf=%b expected q=00 ovf=0", k, obs_q(k), obs_ovf(k));
            else passed++;
        end
        #1 reset = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            tick(1'b0, 1'b0, n[0], 8'hFF);
            total++;
            if (q0 !== 8'h00 || q1 !== 8'h00 || obs_tc[0] !== 1'b0)
                $display("FAIL hold_after_reset edge %0d q=%h/%h tc=%b expected 00/00 tc=0", n, q0, q1, obs_tc[0]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] corners[4] = '{8'h99, 8'h00, 8'hFF, 8'h09};
        for (int n = 0; n < 400; n++) begin
            bit l = ($urandom_range(7) == 0);
            bit e = ($urandom_range(3) != 0);
            bit u = $urandom_range(1);
            logic [7:0] d = ($urandom_range(1) == 0) ? corners[$urandom_range(3)] : 8'($urandom);
            tick(l, e, u, d);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_tc[k] !== exp_tc[k] || obs_q(k) !== enc(mv[k], mb[k]) || obs_ovf(k) !== mo[k])
                    $display("FAIL random dut%0d step %0d l/e/u=%b%b%b tc/q/ovf=%b/%h/%b expected %b/%h/%b",
                             k, n, l, e, u, obs_tc[k], obs_q(k), obs_ovf(k), exp_tc[k], enc(mv[k], mb[k]), mo[k]);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_binary_and_clamp;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctr_digits.md
CTR_DIGITS -- requirements
Module: ctr_digits

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 4, number of cascaded 4-bit digits (1..8).
REQ-002 The block SHALL provide parameter MODE_BCD, default 1, where 1 means each digit counts 0-9 and 0 means each digit counts 0-15 (plain binary nibbles).
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: the asynchronous, active-low reset, so 0 resets.
REQ-005 The block SHALL provide port en, input, 1 bit, count enable.
REQ-006 The block SHALL provide port up, input, 1 bit, direction: 1 = up, 0 = down.
REQ-007 The block SHALL provide port load, input, 1 bit, synchronous parallel load.
REQ-008 The block SHALL provide port din, input, 4*DIGITS bits, load value, digit 0 in bits [3:0].
REQ-009 The block SHALL provide port q, output, 4*DIGITS bits, registered count, digit 0 in bits [3:0].
REQ-010 The block SHALL provide port tc, output, 1 bit, combinational terminal count.
REQ-011 The block SHALL provide port ovf, output, 1 bit, registered sticky wrap/overflow flag.

Function
REQ-012 Per rising edge, priority SHALL be load > en > hold.
REQ-013 load=1 SHALL set q=din on the next edge, with 1-cycle latency, and clear ovf.
REQ-014 In MODE_BCD=1, a loaded digit >9 SHALL be stored as 9.
REQ-015 en=1, up=1 SHALL increment digit 0; a digit at max (9 or 15) SHALL wrap to 0 and carry into the next digit in the same edge.
REQ-016 en=1, up=0 SHALL decrement digit 0; a digit at 0 SHALL wrap to max and borrow from the next digit in the same edge.
REQ-017 en=0 and load=0 SHALL hold q and ovf unchanged.
REQ-018 tc SHALL be 1 when en=1 and either up=1 with every digit at max, or up=0 with every digit at 0; otherwise tc SHALL be 0.
REQ-019 An edge with tc=1 and load=0 SHALL wrap q (all-max to all-zero, or all-zero to all-max) and set ovf=1.
REQ-020 ovf SHALL remain 1 until load or reset.
REQ-021 A change of up SHALL take effect at the next enabled edge, with no extra latency.
REQ-022 Simultaneous load and en with tc=1 SHALL perform the load only: ovf cleared, no wrap.

Reset
REQ-023 reset=0 SHALL immediately, without a clock, force q=0 and ovf=0; tc then follows REQ-018.
REQ-024 reset asserted mid-count SHALL abort the count; counting SHALL resume from 0 on the first rising edge after reset returns to 1.

Configuration
REQ-025 With macro CTR_DIGITS_SAT_EN defined, a tc=1 edge SHALL hold q at all-max when counting up or all-zero when counting down instead of wrapping; ovf SHALL still set.
REQ-026 Without CTR_DIGITS_SAT_EN, wrap behaviour per REQ-019 SHALL apply.

Structure
REQ-027 A shared package SHALL hold the digit-width constant (4), the BCD max (9), the binary max (15), and the direction encodings.
REQ-028 Digit logic SHALL live in one sub-module ctr_digit_cell (inputs: cin, up, load, d; outputs: q, cout), instantiated DIGITS times in a generate loop.
REQ-029 The carry/borrow chain SHALL be combinational, with one register stage per digit only.

Verification
REQ-030 DIGITS=2, MODE_BCD=1; reset low then high; en=1, up=1 for 100 edges -> q counts 00..99; tc=1 at q=99; next edge q=00 and ovf=1.
REQ-031 Load din=0x47; en=1, up=0 for 48 edges -> q reaches 00 after 47 edges; edge 48 gives q=99 and ovf=1; a subsequent load clears ovf.
REQ-032 MODE_BCD=0; load 0x0F; one up edge -> q=0x10 (nibble carry); load 0xFF with en=1, up=1 -> tc=1, next edge q=0x00.
REQ-033 MODE_BCD=1; load din=0xA3 -> q=0x93 (digit clamp); load and en both high at q=99 -> load wins, ovf stays 0.
REQ-034 reset pulled low between clock edges while q=0x56 -> q=00 and ovf=0 with no clock edge; en=0 for 5 edges after release -> q holds 00.
REQ-035 With CTR_DIGITS_SAT_EN: at q=99, up edge -> q stays 99 and ovf=1; at q=00, down edge -> q stays 00.
